// File: rtl/point_collector.sv
// Point collector: detects player/point overlap, counts collected points in BCD
// and runs a respawn request/acknowledge handshake followed by a blanking period.
module point_collector #(
  parameter int POINT_SIZE      = 8,
  parameter int PLAYER_SIZE     = 16,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  point_x,
  input  logic [9:0]  point_y,
  input  logic        point_valid,
  output logic        respawn_req,
  input  logic        respawn_ack,
  output logic        hit_pulse,
  output logic [11:0] score,
  output logic        score_sat,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  // Handshake: respawn_req rises after a hit and is held until respawn_ack is
  // sampled high while in REQ; the transfer completes on that clock edge.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    HIT      = 3'd2,
    REQ      = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam logic [10:0] REACH   = 11'(POINT_SIZE + PLAYER_SIZE);
  localparam logic [7:0]  CD_INIT = 8'(COOLDOWN_CYCLES - 1);

  state_t      r_state;
  logic        r_overlap_q;
  logic [7:0]  r_cnt;
  logic [11:0] r_score;
  logic        r_score_sat;
  logic        r_hit_pulse;
  logic        r_respawn_req;

  logic        w_overlap;
  logic        w_at_max;
  logic [11:0] w_score_inc;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  // Each side adds the reach to the smaller operand so nothing can underflow.
  assign w_overlap = (({1'b0, point_x}  + REACH) > {1'b0, player_x}) &&
                     (({1'b0, player_x} + REACH) > {1'b0, point_x})  &&
                     (({1'b0, point_y}  + REACH) > {1'b0, player_y}) &&
                     (({1'b0, player_y} + REACH) > {1'b0, point_y});

  assign w_at_max    = (r_score == 12'h999);
  assign w_score_inc = bcd_inc(r_score);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overlap_q <= 1'b0;
    end else begin
      r_overlap_q <= w_overlap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_score       <= 12'h000;
      r_score_sat   <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_respawn_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (point_valid) r_state <= ARMED;
        end
        ARMED: begin
          if (!point_valid) begin
            r_state <= IDLE;
          end else if (r_overlap_q) begin
            r_state     <= HIT;
            r_hit_pulse <= 1'b1;
            if (w_at_max) begin
              r_score_sat <= 1'b1;
            end else begin
              r_score     <= w_score_inc;
              r_score_sat <= (w_score_inc == 12'h999);
            end
          end
        end
        HIT: begin
          r_state       <= REQ;
          r_hit_pulse   <= 1'b0;
          r_respawn_req <= 1'b1;
        end
        REQ: begin
          if (respawn_ack) begin
            r_state       <= COOLDOWN;
            r_respawn_req <= 1'b0;
            r_cnt         <= CD_INIT;
          end
        end
        COOLDOWN: begin
          if (r_cnt == 8'd0) begin
            r_state <= point_valid ? ARMED : IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign respawn_req = r_respawn_req;
  assign hit_pulse   = r_hit_pulse;
  assign score       = r_score;
  assign score_sat   = r_score_sat;
  assign busy        = (r_state == HIT) || (r_state == REQ) || (r_state == COOLDOWN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_point_collector.sv
// Directed bench for point_collector: hit/latency, miss boundaries, long handshake,
// cooldown blanking, BCD carries and saturation, and reset in mid-handshake.
module tb_point_collector;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_HIT   = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_COOL  = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  player_x = 10'd500;
  logic [9:0]  player_y = 10'd500;
  logic [9:0]  point_x  = 10'd100;
  logic [9:0]  point_y  = 10'd100;
  logic        point_valid = 1'b0;
  logic        respawn_ack = 1'b0;
  logic        respawn_req;
  logic        hit_pulse;
  logic [11:0] score;
  logic        score_sat;
  logic        busy;
  logic [2:0]  dbg_state;

  int          vectors     = 0;
  int          miscompares = 0;
  int          hits_model  = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;

  point_collector dut (
    .clk         (clk),
    .rst         (rst),
    .player_x    (player_x),
    .player_y    (player_y),
    .point_x     (point_x),
    .point_y     (point_y),
    .point_valid (point_valid),
    .respawn_req (respawn_req),
    .respawn_ack (respawn_ack),
    .hit_pulse   (hit_pulse),
    .score       (score),
    .score_sat   (score_sat),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // Checking helpers
  task automatic check_b(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got state %0d expected state %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Scoreboard: each expected hit pushes {score_sat, score} for the monitor.
  task automatic expect_hit();
    if (hits_model < 999) hits_model++;
    exp_q.push_back({(hits_model == 999), to_bcd(hits_model)});
  endtask

  always @(negedge clk) begin
    if (!rst && hit_pulse) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_hit: got hit with score %03h, none expected", score);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({score_sat, score} !== mon_exp) begin
          miscompares++;
          $display("FAIL hit_score: got sat=%0b score=%03h expected sat=%0b score=%03h",
                   score_sat, score, mon_exp[12], mon_exp[11:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_req(input int bound);
    int n = 0;
    while (!respawn_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_b("req_wait", respawn_req, 1'b1);
  endtask

  task automatic wait_not_busy(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_b("busy_wait", busy, 1'b0);
  endtask

  task automatic ack_pulse();
    respawn_ack = 1'b1;
    @(negedge clk);
    respawn_ack = 1'b0;
  endtask

  task automatic collect();
    expect_hit();
    point_x = 10'd100; point_y = 10'd100;
    player_x = 10'd100; player_y = 10'd100;
    point_valid = 1'b1;
    wait_req(10);
    player_x = 10'd500; player_y = 10'd500;
    ack_pulse();
    wait_not_busy(40);
  endtask

  // Main stimulus
  initial begin
    repeat (2) @(negedge clk);
    check_st("reset_state", dbg_state, S_IDLE);
    check_s ("reset_score", score, 12'h000);
    check_b ("reset_sat", score_sat, 1'b0);
    check_b ("reset_hit", hit_pulse, 1'b0);
    check_b ("reset_req", respawn_req, 1'b0);
    check_b ("reset_busy", busy, 1'b0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_st("idle_wait_valid", dbg_state, S_IDLE);

    // Just-missing positions in x then y
    point_valid = 1'b1;
    player_x = 10'd124; player_y = 10'd100;
    repeat (5) @(negedge clk);
    check_st("miss_x_state", dbg_state, S_ARMED);
    check_s ("miss_x_score", score, 12'h000);
    player_x = 10'd100; player_y = 10'd124;
    repeat (5) @(negedge clk);
    check_st("miss_y_state", dbg_state, S_ARMED);
    check_s ("miss_y_score", score, 12'h000);

    // Edge-of-reach hit and its latency
    expect_hit();
    player_x = 10'd123; player_y = 10'd100;
    @(negedge clk);
    check_b ("lat_n_hit", hit_pulse, 1'b0);
    check_st("lat_n_state", dbg_state, S_ARMED);
    @(negedge clk);
    check_b ("lat_n1_hit", hit_pulse, 1'b1);
    check_b ("lat_n1_req", respawn_req, 1'b0);
    check_st("lat_n1_state", dbg_state, S_HIT);
    @(negedge clk);
    check_b ("lat_n2_hit", hit_pulse, 1'b0);
    check_b ("lat_n2_req", respawn_req, 1'b1);
    check_s ("first_score", score, 12'h001);

    // Long handshake with overlap held throughout
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_b("req_hold", respawn_req, 1'b1);
    end
    ack_pulse();
    check_b ("ack_req_drop", respawn_req, 1'b0);
    check_b ("ack_busy", busy, 1'b1);
    check_st("ack_state", dbg_state, S_COOL);
    expect_hit();
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check_b("cooldown_busy", busy, 1'b1);
    end
    @(negedge clk);
    check_b ("cooldown_end_busy", busy, 1'b0);
    check_b ("cooldown_end_hit", hit_pulse, 1'b0);
    check_st("cooldown_end_state", dbg_state, S_ARMED);
    @(negedge clk);
    check_b ("rehit_pulse", hit_pulse, 1'b1);
    player_x = 10'd500; player_y = 10'd500;
    wait_req(5);
    ack_pulse();
    wait_not_busy(40);

    // point_valid drop has priority over a registered overlap
    player_x = 10'd100; player_y = 10'd100;
    @(negedge clk);
    check_st("pre_drop_state", dbg_state, S_ARMED);
    point_valid = 1'b0;
    @(negedge clk);
    check_st("valid_drop_state", dbg_state, S_IDLE);
    check_b ("valid_drop_hit", hit_pulse, 1'b0);
    point_x = 10'd0; point_y = 10'd0; player_x = 10'd0; player_y = 10'd0;
    repeat (5) @(negedge clk);
    check_st("origin_invalid_state", dbg_state, S_IDLE);
    check_s ("origin_invalid_score", score, 12'h002);

    // Asynchronous reset while requesting
    expect_hit();
    point_x = 10'd100; point_y = 10'd100; player_x = 10'd100; player_y = 10'd100;
    point_valid = 1'b1;
    wait_req(10);
    #2;
    rst = 1'b1;
    #1;
    check_b ("async_rst_req", respawn_req, 1'b0);
    check_s ("async_rst_score", score, 12'h000);
    check_st("async_rst_state", dbg_state, S_IDLE);
    check_b ("async_rst_busy", busy, 1'b0);
    hits_model = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    point_valid = 1'b0;
    player_x = 10'd500; player_y = 10'd500;
    ack_pulse();
    @(negedge clk);
    check_st("post_rst_ack_state", dbg_state, S_IDLE);
    check_b ("post_rst_ack_req", respawn_req, 1'b0);
    check_s ("post_rst_ack_score", score, 12'h000);

    // BCD carries and saturation
    for (int i = 1; i <= 1000; i++) begin
      collect();
      case (i)
        9:    check_s("bcd_9", score, 12'h009);
        10:   check_s("bcd_10", score, 12'h010);
        99:   check_s("bcd_99", score, 12'h099);
        100:  check_s("bcd_100", score, 12'h100);
        998:  check_b("sat_before", score_sat, 1'b0);
        999:  check_b("sat_at_999", score_sat, 1'b1);
        1000: begin
          check_s("sat_hold_score", score, 12'h999);
          check_b("sat_hold_flag", score_sat, 1'b1);
        end
        default: ;
      endcase
    end

    check_s("scoreboard_drained", 12'(exp_q.size()), 12'h000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/point_collector.md
POINT_COLLECTOR -- requirements
Module: point_collector

Interface
REQ-001 Parameter: POINT_SIZE, default 8, point half-size in pixels.
REQ-002 Parameter: PLAYER_SIZE, default 16, player half-size in pixels.
REQ-003 Parameter: COOLDOWN_CYCLES, default 16, detection blanking after respawn ack; legal range 1..255.
REQ-004 Port: clk  in  1  single clock for all state.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: player_x, player_y  in  10 each  player centre.
REQ-007 Port: point_x, point_y  in  10 each  point centre, driven by the point generator.
REQ-008 Port: point_valid  in  1  generator reports the point is on screen.
REQ-009 Port: respawn_req  out  1  registered request to the generator to relocate the point.
REQ-010 Port: respawn_ack  in  1  generator accepted the relocation.
REQ-011 Port: hit_pulse  out  1  registered, one cycle per collected point.
REQ-012 Port: score  out  12  three BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-013 Port: score_sat  out  1  score has reached 999.
REQ-014 Port: busy  out  1  high in HIT, REQ and COOLDOWN states.

Function
REQ-015 Overlap SHALL be computed in 11-bit unsigned arithmetic, with no underflow: (point_x+POINT_SIZE+PLAYER_SIZE > player_x) AND (player_x+POINT_SIZE+PLAYER_SIZE > point_x), plus the same two terms in y.
REQ-016 Overlap SHALL be registered every cycle into overlap_q, regardless of state.
REQ-017 FSM states SHALL be IDLE, ARMED, HIT, REQ and COOLDOWN.
REQ-018 IDLE -> ARMED on an edge with point_valid=1; otherwise the FSM stays in IDLE.
REQ-019 ARMED -> IDLE on an edge with point_valid=0; this has priority over overlap.
REQ-020 ARMED -> HIT on an edge with point_valid=1 and overlap_q=1; on the same edge hit_pulse<=1 and score<=score+1.
REQ-021 HIT -> REQ unconditionally on the next edge; on that edge hit_pulse<=0 and respawn_req<=1.
REQ-022 In REQ, respawn_req SHALL stay high until respawn_ack=1 is sampled.
REQ-023 On that edge the FSM moves REQ -> COOLDOWN, with respawn_req<=0 and cnt<=COOLDOWN_CYCLES-1.
REQ-024 respawn_ack SHALL be ignored in every state other than REQ.
REQ-025 point_valid is not examined while in REQ.
REQ-026 In COOLDOWN, cnt SHALL decrement each edge.
REQ-027 On the edge with cnt=0 the FSM leaves COOLDOWN: to ARMED if point_valid=1, else to IDLE.
REQ-028 Hit-to-request latency: overlapping inputs at edge N give overlap_q=1 after N, hit_pulse high after N+1, and respawn_req high after N+2.
REQ-029 The score SHALL increment in BCD: a units digit of 9 wraps to 0 with carry to tens, and tens carries to hundreds in the same way.
REQ-030 At score 999 (12'h999) further hits SHALL leave the score unchanged and set score_sat=1.
REQ-031 Saturated hits SHALL still pulse hit_pulse and issue respawn_req.
REQ-032 score_sat SHALL be a registered flag that is high whenever score=12'h999.
REQ-033 At most one hit SHALL be counted per respawn handshake; a continuous overlap after cooldown counts again only once cooldown ends.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, score=0, score_sat=0, hit_pulse=0, respawn_req=0, overlap_q=0, cnt=0, busy=0.
REQ-035 Reset mid-handshake SHALL drop respawn_req immediately; a respawn_ack arriving after reset is ignored.
REQ-036 After rst is released, the FSM SHALL wait in IDLE for point_valid.

Verification
REQ-037 With point_valid=1, point (100,100) and player (123,100): hit_pulse high for exactly 1 cycle, score=12'h001, respawn_req high 2 edges after overlap_q rises.
REQ-038 Point (100,100) with player (124,100), then with player (100,124): no hit_pulse, score stays 0, state stays ARMED.
REQ-039 respawn_ack held low for 50 cycles, then pulsed for 1 cycle: respawn_req stays high all 50 cycles, then drops on the ack edge, busy stays high for COOLDOWN_CYCLES=16 further cycles, and a held overlap produces the next hit_pulse only after that.
REQ-040 Score preloaded via 9 and 99 hits: score reads 12'h009 -> 12'h010 and 12'h099 -> 12'h100; from 12'h999 a further hit leaves 12'h999, score_sat=1, and hit_pulse still fires.
REQ-041 point_valid=0 together with overlap_q=1 in ARMED: the FSM goes to IDLE, no hit; point_valid=0 with point at (0,0) and player at (0,0): no hit.
REQ-042 rst asserted in REQ, asynchronously and not on a clock edge: respawn_req=0, score=0 and state=IDLE immediately; a respawn_ack pulse after release causes no change.
